adc_drp_sampler: RTL and testbench
==================================

Name: adc_drp_sampler

Overview:
- Parametrised multi-channel XADC DRP reader. Replaces the fixed single-channel ADC wrapper (VAUX6 only, EOC tied straight to DEN).
- Sits between an externally instantiated xadc_wiz in channel-sequencer mode and downstream FIFO/FIR logic.
- On each end-of-conversion, reads the matching status register over DRP, optionally averages 2^AVG_LOG2 samples per channel, and emits a channel-tagged result on a valid/ready stream.
- Adds DRDY timeout, overrun detection and missed-EOC detection.

Parameters:
- NUM_CH, 1, number of consecutive VAUX channels served (1..16).
- CH_BASE, 6, first VAUX index; CH_BASE+NUM_CH <= 16.
- AVG_LOG2, 0, log2 of samples averaged per channel (0..4; 0 = no averaging).
- DATA_W, 12, output sample width; 1 <= DATA_W <= 12+AVG_LOG2.
- TIMEOUT, 15, cycles to wait for DRDY after DEN before aborting (>= 2).

Ports:
- clk_78MHz_i  in  1  system/DRP clock.
- reset_i  in  1  synchronous, active-high reset.
- eoc_i  in  1  XADC eoc_out.
- channel_i  in  5  XADC channel_out, sampled with eoc_i.
- den_o  out  1  DRP enable, one-cycle pulse.
- daddr_o  out  7  DRP address.
- dwe_o  out  1  DRP write enable; constant 0.
- di_o  out  16  DRP write data; constant 0.
- drdy_i  in  1  DRP data ready.
- do_i  in  16  DRP read data.
- data_o  out  DATA_W  result sample.
- ch_o  out  4  result channel index, 0..NUM_CH-1, relative to CH_BASE.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream ready.
- overrun_o  out  1  sticky: a result was dropped.
- timeout_o  out  1  sticky: a DRDY timeout occurred.
- missed_o  out  1  sticky: an EOC arrived while busy.

Behaviour:
- Reset: all outputs 0 (den_o, daddr_o, data_o, ch_o, valid_o, sticky flags); FSM to IDLE; all accumulators and counters 0. Reset mid-transaction aborts it, with no output.
- Channel acceptance:
  - eoc_i is accepted only when channel_i lies in [16+CH_BASE, 16+CH_BASE+NUM_CH-1].
  - Other channels are ignored and do not set missed_o.
  - idx = channel_i-16-CH_BASE.
- FSM states:
  - IDLE: on accepted eoc_i, register idx and daddr_o = {2'b00,channel_i}; den_o = 1 for exactly the next cycle; go to WAIT.
  - WAIT: a timer counts cycles since den_o.
    - On drdy_i: latch raw = do_i[15:4] (12 bits) and go to ACC.
    - If the timer reaches TIMEOUT without drdy_i: set timeout_o, discard the sample, go to IDLE.
  - ACC (1 cycle): sum = acc[idx] + raw; cnt[idx]++.
    - If cnt[idx] was 2^AVG_LOG2-1: result = sum >> (12+AVG_LOG2-DATA_W); clear acc[idx] and cnt[idx]; go to EMIT.
    - Otherwise store acc[idx] = sum and go to IDLE.
  - EMIT (1 cycle):
    - If valid_o is low, or valid_o&&ready_i this cycle: load data_o/ch_o and set valid_o.
    - Otherwise drop the result and set overrun_o.
    - Go to IDLE.
- Latency: drdy_i high at cycle t -> valid_o high at t+3 (ACC at t+1, EMIT at t+2, register visible t+3).
- Output handshake:
  - valid_o stays high, with data_o/ch_o stable, until a cycle with ready_i=1; it clears the next cycle unless EMIT reloads it in the same cycle.
- Accumulator width is 12+AVG_LOG2 per channel, unsigned; no overflow is possible.
- eoc_i in WAIT/ACC/EMIT sets missed_o and is otherwise ignored; no queueing.
- eoc_i coincident with the transition to IDLE is also ignored: only IDLE samples eoc_i.
- drdy_i outside WAIT is ignored.
- Sticky flags clear only on reset_i.

Decomposition:
- Package adc_drp_pkg:
  - XADC_VAUX_BASE = 5'd16.
  - ADC_RAW_W = 12.
  - FSM state enum (IDLE, WAIT, ACC, EMIT).
  - Function computing the result shift.
- One natural sub-module: adc_ch_accum.
  - Per-channel accumulator/count register bank.
  - Indexed read / write / clear.

Test Plan:
- Default params: eoc_i with channel_i=22; model returns do_i=16'hABC0 after 3 cycles -> daddr_o=7'h16, den_o single pulse, data_o=12'hABC, ch_o=0, valid_o 3 cycles after drdy_i.
- NUM_CH=2, AVG_LOG2=2, DATA_W=12:
  - ch6 samples raw 100, 200, 300, 400 -> one result, data_o=250, ch_o=0.
  - ch7 samples interleaved accumulate independently.
- DRP model never asserts drdy_i -> timeout_o=1 at TIMEOUT cycles after den_o, no valid_o; next EOC is processed normally.
- ready_i=0 held, two results produced -> first held stable on data_o, second dropped, overrun_o=1.
- eoc_i re-asserted during WAIT -> missed_o=1, exactly one den_o pulse; eoc_i with channel_i=3 -> no den_o.
- reset_i asserted in WAIT with drdy_i arriving next cycle -> no valid_o; all outputs 0; next transaction correct.

Source files
------------

// File: rtl/adc_drp_pkg.sv
// Shared constants, FSM state type and result-scaling helper for the XADC DRP sampler.
package adc_drp_pkg;

  localparam logic [4:0] XADC_VAUX_BASE = 5'd16;
  localparam int         ADC_RAW_W      = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    EMIT = 2'd3
  } state_e;

  // Right shift that turns a sum of 2^avg_log2 raw samples into a data_w-bit mean.
  function automatic int result_shift(input int avg_log2, input int data_w);
    return ADC_RAW_W + avg_log2 - data_w;
  endfunction

endpackage

// File: rtl/adc_drp_sampler_if.sv
// XADC-facing DRP/EOC signals and the downstream result stream of the DRP sampler.
interface adc_drp_sampler_if #(
  parameter int DATA_W = 12
);

  logic              eoc_i;
  logic [4:0]        channel_i;
  logic              den_o;
  logic [6:0]        daddr_o;
  logic              dwe_o;
  logic [15:0]       di_o;
  logic              drdy_i;
  logic [15:0]       do_i;
  logic [DATA_W-1:0] data_o;
  logic [3:0]        ch_o;
  logic              valid_o;
  logic              ready_i;
  logic              overrun_o;
  logic              timeout_o;
  logic              missed_o;

  modport master (
    input  eoc_i, channel_i, drdy_i, do_i, ready_i,
    output den_o, daddr_o, dwe_o, di_o, data_o, ch_o, valid_o,
           overrun_o, timeout_o, missed_o
  );

  modport slave (
    output eoc_i, channel_i, drdy_i, do_i, ready_i,
    input  den_o, daddr_o, dwe_o, di_o, data_o, ch_o, valid_o,
           overrun_o, timeout_o, missed_o
  );

endinterface

// File: rtl/adc_ch_accum.sv
// Per-channel running sum and sample count, with one indexed read port and one write/clear port.
module adc_ch_accum
  import adc_drp_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int ACC_W  = ADC_RAW_W,
  parameter int CNT_W  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       idx,
  input  logic             wr_en,
  input  logic             clr,
  input  logic [ACC_W-1:0] wr_acc,
  input  logic [CNT_W-1:0] wr_cnt,
  output logic [ACC_W-1:0] rd_acc,
  output logic [CNT_W-1:0] rd_cnt
);

  // Bank is padded to a power of two so every index value selects a real entry.
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DEPTH = 1 << IDX_W;

  logic [IDX_W-1:0] sel_s;
  logic [ACC_W-1:0] acc_r [DEPTH];
  logic [CNT_W-1:0] cnt_r [DEPTH];
  logic             unused_idx_s;

  assign sel_s        = idx[IDX_W-1:0];
  assign unused_idx_s = ^idx;

  // Combinational read of the selected channel.
  always_comb begin
    rd_acc = acc_r[sel_s];
    rd_cnt = cnt_r[sel_s];
  end

  // Reset clears the whole bank; clear takes priority over write for the selected entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        acc_r[i] <= {ACC_W{1'b0}};
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else if (wr_en && clr) begin
      acc_r[sel_s] <= {ACC_W{1'b0}};
      cnt_r[sel_s] <= {CNT_W{1'b0}};
    end else if (wr_en) begin
      acc_r[sel_s] <= wr_acc;
      cnt_r[sel_s] <= wr_cnt;
    end
  end

endmodule

// File: rtl/adc_drp_sampler.sv
// Multi-channel XADC DRP reader: on EOC reads the channel's status register, optionally
// averages per channel, and emits channel-tagged results with timeout/overrun/missed flags.
module adc_drp_sampler
  import adc_drp_pkg::*;
#(
  parameter int NUM_CH   = 1,
  parameter int CH_BASE  = 6,
  parameter int AVG_LOG2 = 0,
  parameter int DATA_W   = 12,
  parameter int TIMEOUT  = 15
) (
  input  logic               clk_78MHz_i,
  input  logic               reset_i,
  adc_drp_sampler_if.master  bus
);

  localparam int                ACC_W    = ADC_RAW_W + AVG_LOG2;
  localparam int                CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int                SHIFT    = result_shift(AVG_LOG2, DATA_W);
  localparam int                TMR_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [4:0]        CH_LO    = XADC_VAUX_BASE + 5'(CH_BASE);
  localparam logic [4:0]        CH_HI    = CH_LO + 5'(NUM_CH - 1);

  state_e            state_r;
  logic [3:0]        idx_r;
  logic [6:0]        daddr_r;
  logic              den_r;
  logic [TMR_W-1:0]  tmr_r;
  logic [11:0]       raw_r;
  logic [DATA_W-1:0] res_r;
  logic [DATA_W-1:0] data_r;
  logic [3:0]        ch_r;
  logic              valid_r;
  logic              overrun_r;
  logic              timeout_r;
  logic              missed_r;

  logic              eoc_hit_s;
  logic [4:0]        eoc_off_s;
  logic [ACC_W-1:0]  rd_acc_s;
  logic [CNT_W-1:0]  rd_cnt_s;
  logic [ACC_W-1:0]  sum_s;
  logic [ACC_W-1:0]  shifted_s;
  logic              last_s;
  logic              acc_wr_s;
  logic              acc_clr_s;
  logic              unused_ok_s;

  // Accept only EOCs for the served VAUX window.
  always_comb begin
    eoc_off_s = bus.channel_i - CH_LO;
    eoc_hit_s = 1'b0;
    if (bus.eoc_i && (bus.channel_i >= CH_LO) && (bus.channel_i <= CH_HI)) begin
      eoc_hit_s = 1'b1;
    end else begin
      eoc_hit_s = 1'b0;
    end
  end

  // Accumulator update terms, only committed while in ACC.
  always_comb begin
    sum_s     = rd_acc_s + ACC_W'(raw_r);
    shifted_s = sum_s >> SHIFT;
    last_s    = (rd_cnt_s == CNT_LAST);
    acc_wr_s  = (state_r == ACC);
    acc_clr_s = acc_wr_s && last_s;
  end

  adc_ch_accum #(
    .NUM_CH (NUM_CH),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) u_accum (
    .clk    (clk_78MHz_i),
    .reset  (reset_i),
    .idx    (idx_r),
    .wr_en  (acc_wr_s),
    .clr    (acc_clr_s),
    .wr_acc (sum_s),
    .wr_cnt (rd_cnt_s + CNT_W'(1)),
    .rd_acc (rd_acc_s),
    .rd_cnt (rd_cnt_s)
  );

  // Sequencer FSM with registered DRP strobes, result stream and sticky flags.
  always_ff @(posedge clk_78MHz_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      idx_r     <= 4'd0;
      daddr_r   <= 7'd0;
      den_r     <= 1'b0;
      tmr_r     <= {TMR_W{1'b0}};
      raw_r     <= 12'd0;
      res_r     <= {DATA_W{1'b0}};
      data_r    <= {DATA_W{1'b0}};
      ch_r      <= 4'd0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
      missed_r  <= 1'b0;
    end else begin
      den_r <= 1'b0;
      if (valid_r && bus.ready_i) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (eoc_hit_s) begin
            idx_r   <= eoc_off_s[3:0];
            daddr_r <= {2'b00, bus.channel_i};
            den_r   <= 1'b1;
            tmr_r   <= {TMR_W{1'b0}};
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (bus.drdy_i) begin
            raw_r   <= bus.do_i[15:4];
            state_r <= ACC;
          end else if (tmr_r == TMR_LAST) begin
            timeout_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        ACC: begin
          if (last_s) begin
            res_r   <= shifted_s[DATA_W-1:0];
            state_r <= EMIT;
          end else begin
            state_r <= IDLE;
          end
        end
        EMIT: begin
          // A result still waiting downstream is kept; the new one is dropped.
          if (!valid_r || bus.ready_i) begin
            data_r  <= res_r;
            ch_r    <= idx_r;
            valid_r <= 1'b1;
          end else begin
            overrun_r <= 1'b1;
          end
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
      if ((state_r != IDLE) && eoc_hit_s) begin
        missed_r <= 1'b1;
      end
    end
  end

  assign bus.den_o     = den_r;
  assign bus.daddr_o   = daddr_r;
  assign bus.dwe_o     = 1'b0;
  assign bus.di_o      = 16'h0000;
  assign bus.data_o    = data_r;
  assign bus.ch_o      = ch_r;
  assign bus.valid_o   = valid_r;
  assign bus.overrun_o = overrun_r;
  assign bus.timeout_o = timeout_r;
  assign bus.missed_o  = missed_r;
  assign unused_ok_s   = ^{bus.do_i[3:0], eoc_off_s[4]};

endmodule

// File: tb/tb_adc_drp_sampler.sv
// Scoreboard bench: instance A uses default parameters, instance B averages 4 samples over 2 channels.
module tb_adc_drp_sampler;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   total = 0;
  int   bad   = 0;
  int   den_cnt_a = 0;
  int   den_base;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  int   acc_m [2];
  int   cnt_m [2];

  always #6 clk = ~clk;

  adc_drp_sampler_if #(.DATA_W(12)) ifa ();
  adc_drp_sampler_if #(.DATA_W(12)) ifb ();

  adc_drp_sampler u_a (
    .clk_78MHz_i (clk),
    .reset_i     (reset_a),
    .bus         (ifa)
  );

  adc_drp_sampler #(
    .NUM_CH   (2),
    .CH_BASE  (6),
    .AVG_LOG2 (2),
    .DATA_W   (12),
    .TIMEOUT  (15)
  ) u_b (
    .clk_78MHz_i (clk),
    .reset_i     (reset_b),
    .bus         (ifb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on every accepted result; also count DEN high cycles on A.
  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (ifa.valid_o && ifa.ready_i) begin
      check_eq("a_sb_avail", 32'(exp_a.size() > 0), 32'd1);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check_eq("a_data", 32'(ifa.data_o), 32'(e[11:0]));
        check_eq("a_ch", 32'(ifa.ch_o), 32'(e[15:12]));
      end
    end
    if (ifb.valid_o && ifb.ready_i) begin
      check_eq("b_sb_avail", 32'(exp_b.size() > 0), 32'd1);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check_eq("b_data", 32'(ifb.data_o), 32'(e[11:0]));
        check_eq("b_ch", 32'(ifb.ch_o), 32'(e[15:12]));
      end
    end
    if (ifa.den_o) den_cnt_a++;
  end

  task automatic pulse_eoc_a(input logic [4:0] ch);
    ifa.eoc_i     = 1'b1;
    ifa.channel_i = ch;
    step();
    ifa.eoc_i     = 1'b0;
  endtask

  task automatic drdy_a(input logic [15:0] dat);
    ifa.drdy_i = 1'b1;
    ifa.do_i   = dat;
    step();
    ifa.drdy_i = 1'b0;
    ifa.do_i   = 16'h0000;
  endtask

  // Full read on channel 22 of A; the result is pushed unless it is expected to be dropped.
  task automatic xact_a(input logic [15:0] dat, input bit push);
    pulse_eoc_a(5'd22);
    check_eq("a_den_go", 32'(ifa.den_o), 32'd1);
    step();
    step();
    if (push) exp_a.push_back({4'd0, dat[15:4]});
    drdy_a(dat);
    step();
    step();
  endtask

  task automatic check_zero_a(input string tag);
    check_eq({tag, "_den"}, 32'(ifa.den_o), 32'd0);
    check_eq({tag, "_daddr"}, 32'(ifa.daddr_o), 32'd0);
    check_eq({tag, "_data"}, 32'(ifa.data_o), 32'd0);
    check_eq({tag, "_ch"}, 32'(ifa.ch_o), 32'd0);
    check_eq({tag, "_valid"}, 32'(ifa.valid_o), 32'd0);
    check_eq({tag, "_ovr"}, 32'(ifa.overrun_o), 32'd0);
    check_eq({tag, "_tmo"}, 32'(ifa.timeout_o), 32'd0);
    check_eq({tag, "_miss"}, 32'(ifa.missed_o), 32'd0);
  endtask

  // One read on B with a local averaging model producing the expected result.
  task automatic xact_b(input logic [4:0] ch, input logic [11:0] raw);
    int i;
    i = int'(ch) - 22;
    ifb.eoc_i     = 1'b1;
    ifb.channel_i = ch;
    step();
    ifb.eoc_i     = 1'b0;
    check_eq("b_den", 32'(ifb.den_o), 32'd1);
    check_eq("b_daddr", 32'(ifb.daddr_o), 32'(ch));
    acc_m[i] += int'(raw);
    cnt_m[i]++;
    if (cnt_m[i] == 4) begin
      exp_b.push_back({4'(i), 12'(acc_m[i] / 4)});
      acc_m[i] = 0;
      cnt_m[i] = 0;
    end
    step();
    ifb.drdy_i = 1'b1;
    ifb.do_i   = {raw, 4'h0};
    step();
    ifb.drdy_i = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    ifa.eoc_i = 1'b0; ifa.channel_i = 5'd0; ifa.drdy_i = 1'b0; ifa.do_i = 16'h0000; ifa.ready_i = 1'b1;
    ifb.eoc_i = 1'b0; ifb.channel_i = 5'd0; ifb.drdy_i = 1'b0; ifb.do_i = 16'h0000; ifb.ready_i = 1'b1;
    acc_m = '{0, 0};
    cnt_m = '{0, 0};
    reset_a = 1'b1;
    reset_b = 1'b1;
    step();
    step();
    check_zero_a("rst");
    check_eq("rst_dwe", 32'(ifa.dwe_o), 32'd0);
    check_eq("rst_di", 32'(ifa.di_o), 32'd0);
    check_eq("rst_b_valid", 32'(ifb.valid_o), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    step();

    // Basic read: address, single DEN pulse, 3-cycle latency from DRDY.
    den_base = den_cnt_a;
    pulse_eoc_a(5'd22);
    check_eq("a_den", 32'(ifa.den_o), 32'd1);
    check_eq("a_daddr", 32'(ifa.daddr_o), 32'h16);
    step();
    check_eq("a_den_pulse", 32'(ifa.den_o), 32'd0);
    step();
    exp_a.push_back({4'd0, 12'hABC});
    drdy_a(16'hABC0);
    check_eq("a_lat1", 32'(ifa.valid_o), 32'd0);
    step();
    check_eq("a_lat2", 32'(ifa.valid_o), 32'd0);
    step();
    check_eq("a_lat3", 32'(ifa.valid_o), 32'd1);
    check_eq("a_data0", 32'(ifa.data_o), 32'hABC);
    step();
    check_eq("a_valid_clr", 32'(ifa.valid_o), 32'd0);
    check_eq("a_den_count", 32'(den_cnt_a - den_base), 32'd1);

    // Out-of-window channels are ignored without flagging missed.
    pulse_eoc_a(5'd3);
    check_eq("a_ch3_den", 32'(ifa.den_o), 32'd0);
    pulse_eoc_a(5'd23);
    check_eq("a_ch23_den", 32'(ifa.den_o), 32'd0);
    check_eq("a_ign_miss", 32'(ifa.missed_o), 32'd0);

    // DRDY never comes: timeout exactly 15 cycles after DEN.
    pulse_eoc_a(5'd22);
    repeat (14) step();
    check_eq("a_tmo_early", 32'(ifa.timeout_o), 32'd0);
    step();
    check_eq("a_tmo", 32'(ifa.timeout_o), 32'd1);
    repeat (3) step();
    check_eq("a_tmo_novalid", 32'(ifa.valid_o), 32'd0);
    xact_a(16'h1230, 1'b1);
    check_eq("a_after_tmo", 32'(ifa.data_o), 32'h123);

    // EOC while waiting for DRDY: flagged, not served.
    den_base = den_cnt_a;
    pulse_eoc_a(5'd22);
    pulse_eoc_a(5'd22);
    check_eq("a_miss_den", 32'(ifa.den_o), 32'd0);
    check_eq("a_miss", 32'(ifa.missed_o), 32'd1);
    exp_a.push_back({4'd0, 12'h555});
    drdy_a(16'h5550);
    step();
    step();
    check_eq("a_miss_data", 32'(ifa.data_o), 32'h555);
    check_eq("a_miss_dens", 32'(den_cnt_a - den_base), 32'd1);
    step();

    // Stalled downstream: first result held, second dropped.
    ifa.ready_i = 1'b0;
    xact_a(16'h1110, 1'b1);
    check_eq("a_hold_valid", 32'(ifa.valid_o), 32'd1);
    check_eq("a_ovr_pre", 32'(ifa.overrun_o), 32'd0);
    xact_a(16'h2220, 1'b0);
    check_eq("a_hold_data", 32'(ifa.data_o), 32'h111);
    check_eq("a_hold_valid2", 32'(ifa.valid_o), 32'd1);
    check_eq("a_ovr", 32'(ifa.overrun_o), 32'd1);
    ifa.ready_i = 1'b1;
    step();
    check_eq("a_drain", 32'(ifa.valid_o), 32'd0);

    // Reset in WAIT with DRDY right after: aborted, everything cleared.
    pulse_eoc_a(5'd22);
    step();
    reset_a = 1'b1;
    step();
    reset_a = 1'b0;
    drdy_a(16'hFFF0);
    step();
    step();
    step();
    check_zero_a("mid_rst");
    xact_a(16'h4560, 1'b1);
    check_eq("a_post_rst", 32'(ifa.data_o), 32'h456);
    step();

    // B: interleaved channels average independently.
    xact_b(5'd22, 12'd100);
    xact_b(5'd23, 12'd1000);
    xact_b(5'd22, 12'd200);
    xact_b(5'd23, 12'd2000);
    xact_b(5'd22, 12'd300);
    check_eq("b_no_early", 32'(ifb.valid_o), 32'd0);
    xact_b(5'd23, 12'd3000);
    xact_b(5'd22, 12'd400);
    check_eq("b_avg0", 32'(ifb.data_o), 32'd250);
    xact_b(5'd23, 12'd4000);
    check_eq("b_avg1", 32'(ifb.data_o), 32'd2500);
    step();

    check_eq("a_sb_empty", 32'(exp_a.size()), 32'd0);
    check_eq("b_sb_empty", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
